fir_seq_axi: RTL and testbench

- Parametrised successor to the team's single-channel FIR. Run-time tap count up to pTAP_MAX and run-time data length, set over AXI-Lite.
- A single shared multiply-accumulate (MAC) unit computes one tap per cycle.
- Samples enter on an AXI-Stream slave and results leave on an AXI-Stream master. The host controls the block through an ap_start/ap_done/ap_idle register.
- Sits between the host CPU's AXI-Lite bus and the stream DMA in the SoC test harness.

---
 rtl/fir_seq_axi.sv | 251 +++++++++++++++++++++++++
 tb/tb_fir_seq_axi.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_seq_axi.sv
// Sequential FIR: one shared MAC computes one tap per cycle, AXI-Lite control and taps,
// AXI-Stream samples in and results out.
module fir_seq_axi #(
    parameter int unsigned pADDR_WIDTH = 12,
    parameter int unsigned pDATA_WIDTH = 32,
    parameter int unsigned pTAP_MAX    = 32
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    // AXI-Lite write
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    // AXI-Lite read
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    // AXI-Stream in
    input  logic                   ss_tvalid,
    output logic                   ss_tready,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    // AXI-Stream out
    output logic                   sm_tvalid,
    input  logic                   sm_tready,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast
);

    localparam int unsigned IdxW    = $clog2(pTAP_MAX);
    localparam int unsigned TapBase = 'h80;
    localparam int unsigned TapEnd  = TapBase + 4 * pTAP_MAX;

    localparam logic [pADDR_WIDTH-1:0] AddrCtrl   = pADDR_WIDTH'('h00);
    localparam logic [pADDR_WIDTH-1:0] AddrLength = pADDR_WIDTH'('h10);
    localparam logic [pADDR_WIDTH-1:0] AddrTapNum = pADDR_WIDTH'('h14);

    typedef enum logic [2:0] {StIdle, StClr, StWaitIn, StMac, StOut, StDone} state_e;

    state_e                 state_q;
    logic [pDATA_WIDTH-1:0] tap_q [pTAP_MAX];
    logic [pDATA_WIDTH-1:0] smp_q [pTAP_MAX];
    logic [pDATA_WIDTH-1:0] data_length_q;
    logic [pDATA_WIDTH-1:0] smp_cnt_q;
    logic [pDATA_WIDTH-1:0] acc_q;
    logic [5:0]             tap_num_q;
    logic [5:0]             cnt_q;
    logic [IdxW-1:0]        wr_ptr_q;
    logic [IdxW-1:0]        rd_ptr_q;
    logic                   ap_start_q;
    logic                   ap_done_q;
    logic                   ap_idle_q;

    logic                     wr_fire;
    logic                     rd_fire;
    logic                     rd_ctrl;
    logic                     start_fire;
    logic                     sm_fire;
    logic                     last_out;
    logic                     done_evt;
    logic [pDATA_WIDTH-1:0]   rd_val;
    logic [2*pDATA_WIDTH-1:0] prod;
    logic                     unused_ok;

    function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
        return (a >= pADDR_WIDTH'(TapBase)) && (a < pADDR_WIDTH'(TapEnd)) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [IdxW-1:0] tap_idx(input logic [pADDR_WIDTH-1:0] a);
        return IdxW'((a - pADDR_WIDTH'(TapBase)) >> 2);
    endfunction

    function automatic logic [IdxW-1:0] ptr_inc(input logic [IdxW-1:0] p);
        return (p == IdxW'(pTAP_MAX - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [IdxW-1:0] ptr_dec(input logic [IdxW-1:0] p);
        return (p == '0) ? IdxW'(pTAP_MAX - 1) : p - 1'b1;
    endfunction

    assign wr_fire    = awvalid && wvalid && awready;
    assign rd_fire    = arvalid && arready;
    assign rd_ctrl    = rd_fire && (araddr == AddrCtrl);
    assign start_fire = wr_fire && (awaddr == AddrCtrl) && wdata[0] && ap_idle_q;
    assign sm_fire    = sm_tvalid && sm_tready;
    assign last_out   = (smp_cnt_q + 1'b1) == data_length_q;
    // Cycles on whose closing edge ap_done becomes set; lets a coincident read still see it.
    assign done_evt   = (start_fire && (data_length_q == '0)) ||
                        (state_q == StOut && sm_fire && last_out);

    assign prod = $signed(tap_q[cnt_q[IdxW-1:0]]) * $signed(smp_q[rd_ptr_q]);

    assign unused_ok = ^{ss_tlast, prod[2*pDATA_WIDTH-1:pDATA_WIDTH]};

    always_comb begin
        rd_val = '0;
        if (araddr == AddrCtrl) begin
            rd_val = {{(pDATA_WIDTH - 3){1'b0}}, ap_idle_q, ap_done_q | done_evt, ap_start_q};
        end else if (araddr == AddrLength) begin
            rd_val = data_length_q;
        end else if (araddr == AddrTapNum) begin
            rd_val = pDATA_WIDTH'(tap_num_q);
        end else if (is_tap(araddr)) begin
            rd_val = ap_idle_q ? tap_q[tap_idx(araddr)] : '1;
        end
    end

    // AXI-Lite write channel and configuration registers
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            awready       <= 1'b0;
            wready        <= 1'b0;
            data_length_q <= '0;
            tap_num_q     <= '0;
            for (int i = 0; i < int'(pTAP_MAX); i++) begin
                tap_q[i] <= '0;
            end
        end else begin
            awready <= awvalid && wvalid && !awready;
            wready  <= awvalid && wvalid && !awready;
            if (wr_fire && ap_idle_q) begin
                if (awaddr == AddrLength) begin
                    data_length_q <= wdata;
                end else if (awaddr == AddrTapNum) begin
                    tap_num_q <= (wdata > pDATA_WIDTH'(pTAP_MAX)) ? 6'(pTAP_MAX) : wdata[5:0];
                end else if (is_tap(awaddr)) begin
                    tap_q[tap_idx(awaddr)] <= wdata;
                end
            end
        end
    end

    // AXI-Lite read channel
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else if (rd_fire) begin
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rdata   <= rd_val;
        end else if (rvalid && rready) begin
            arready <= 1'b1;
            rvalid  <= 1'b0;
        end else if (!rvalid) begin
            arready <= 1'b1;
        end
    end

    // Control FSM and MAC datapath
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q    <= StIdle;
            smp_cnt_q  <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ap_start_q <= 1'b0;
            ap_done_q  <= 1'b0;
            ap_idle_q  <= 1'b1;
            ss_tready  <= 1'b0;
            sm_tvalid  <= 1'b0;
            sm_tdata   <= '0;
            sm_tlast   <= 1'b0;
            for (int i = 0; i < int'(pTAP_MAX); i++) begin
                smp_q[i] <= '0;
            end
        end else begin
            ap_start_q <= start_fire;
            if (rd_ctrl) begin
                ap_done_q <= 1'b0;
            end else if (done_evt) begin
                ap_done_q <= 1'b1;
            end

            unique case (state_q)
                StIdle, StDone: begin
                    if (start_fire) begin
                        smp_cnt_q <= '0;
                        if (data_length_q == '0) begin
                            state_q <= StDone;
                        end else begin
                            state_q   <= StClr;
                            cnt_q     <= '0;
                            ap_idle_q <= 1'b0;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StClr: begin
                    smp_q[cnt_q[IdxW-1:0]] <= '0;
                    cnt_q                  <= cnt_q + 1'b1;
                    if (cnt_q == 6'(pTAP_MAX - 1)) begin
                        state_q   <= StWaitIn;
                        ss_tready <= 1'b1;
                        wr_ptr_q  <= '0;
                    end
                end
                StWaitIn: begin
                    if (ss_tvalid) begin
                        smp_q[wr_ptr_q] <= ss_tdata;
                        rd_ptr_q        <= wr_ptr_q;
                        wr_ptr_q        <= ptr_inc(wr_ptr_q);
                        ss_tready       <= 1'b0;
                        cnt_q           <= '0;
                        acc_q           <= '0;
                        state_q         <= StMac;
                    end
                end
                StMac: begin
                    // One extra cycle after the last tap presents the accumulator
                    if (cnt_q == tap_num_q) begin
                        sm_tvalid <= 1'b1;
                        sm_tdata  <= acc_q;
                        sm_tlast  <= last_out;
                        state_q   <= StOut;
                    end else begin
                        acc_q    <= acc_q + prod[pDATA_WIDTH-1:0];
                        rd_ptr_q <= ptr_dec(rd_ptr_q);
                        cnt_q    <= cnt_q + 1'b1;
                    end
                end
                StOut: begin
                    if (sm_tready) begin
                        sm_tvalid <= 1'b0;
                        sm_tlast  <= 1'b0;
                        smp_cnt_q <= smp_cnt_q + 1'b1;
                        if (last_out) begin
                            state_q   <= StDone;
                            ap_idle_q <= 1'b1;
                        end else begin
                            state_q   <= StWaitIn;
                            ss_tready <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_seq_axi.sv
// Directed bench for fir_seq_axi: register access, filtering, backpressure, busy rules, reset abort.
module tb_fir_seq_axi;

    logic        axis_clk = 1'b0;
    logic        axis_rst_n;
    logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic        ss_tvalid, ss_tready, ss_tlast, sm_tvalid, sm_tready, sm_tlast;
    logic [31:0] ss_tdata, sm_tdata;

    int          checks   = 0;
    int          failures = 0;
    longint      hs_time;
    longint      lat;
    logic [31:0] rd;

    int taps  [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    int exp_y [8]  = '{0, -10, -29, -25, 35, 158, 337, 539};

    always #5 axis_clk = ~axis_clk;

    fir_seq_axi #(
        .pADDR_WIDTH(12),
        .pDATA_WIDTH(32),
        .pTAP_MAX   (32)
    ) dut (
        .axis_clk  (axis_clk),
        .axis_rst_n(axis_rst_n),
        .awvalid   (awvalid),
        .awready   (awready),
        .awaddr    (awaddr),
        .wvalid    (wvalid),
        .wready    (wready),
        .wdata     (wdata),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .ss_tvalid (ss_tvalid),
        .ss_tready (ss_tready),
        .ss_tdata  (ss_tdata),
        .ss_tlast  (ss_tlast),
        .sm_tvalid (sm_tvalid),
        .sm_tready (sm_tready),
        .sm_tdata  (sm_tdata),
        .sm_tlast  (sm_tlast)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic axil_write(input logic [11:0] a, input logic [31:0] d);
        int n = 0;
        awaddr  = a;
        wdata   = d;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        @(negedge axis_clk);
        while (!(awready && wready) && n < 20) begin
            @(negedge axis_clk);
            n++;
        end
        check("aw_handshake", {30'b0, awready, wready}, 32'd3);
        @(negedge axis_clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    task automatic axil_read(input logic [11:0] a, output logic [31:0] d);
        int n = 0;
        araddr  = a;
        arvalid = 1'b1;
        while (!arready && n < 20) begin
            @(negedge axis_clk);
            n++;
        end
        check("ar_handshake", {31'b0, arready}, 32'd1);
        @(negedge axis_clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            @(negedge axis_clk);
            n++;
        end
        check("rvalid_wait", {31'b0, rvalid}, 32'd1);
        d      = rdata;
        rready = 1'b1;
        @(negedge axis_clk);
        rready = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] v;
        axil_read(a, v);
        check(tag, v, exp);
    endtask

    task automatic send_sample(input logic [31:0] d);
        int n = 0;
        ss_tdata  = d;
        ss_tvalid = 1'b1;
        while (!ss_tready && n < 100) begin
            @(negedge axis_clk);
            n++;
        end
        check("ss_tready_wait", {31'b0, ss_tready}, 32'd1);
        @(posedge axis_clk);
        hs_time = $time;
        @(negedge axis_clk);
        ss_tvalid = 1'b0;
    endtask

    task automatic recv_out(input string tag, input logic [31:0] exp, input logic exp_last);
        int n = 0;
        sm_tready = 1'b1;
        while (!sm_tvalid && n < 100) begin
            @(negedge axis_clk);
            n++;
        end
        check({tag, "_valid"}, {31'b0, sm_tvalid}, 32'd1);
        check({tag, "_data"}, sm_tdata, exp);
        check({tag, "_last"}, {31'b0, sm_tlast}, {31'b0, exp_last});
        @(negedge axis_clk);
        sm_tready = 1'b0;
    endtask

    initial begin
        axis_rst_n = 1'b0;
        {awvalid, wvalid, arvalid, rready, ss_tvalid, ss_tlast, sm_tready} = '0;
        awaddr   = '0;
        araddr   = '0;
        wdata    = '0;
        ss_tdata = '0;
        repeat (3) @(negedge axis_clk);
        check("rst_ctl_outs", {25'b0, awready, wready, arready, rvalid, ss_tready, sm_tvalid,
                               sm_tlast}, 32'd0);
        check("rst_sm_tdata", sm_tdata, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        axis_rst_n = 1'b1;
        @(negedge axis_clk);

        // Idle status and tap programming
        rd_check("ctrl_after_reset", 12'h000, 32'h4);
        for (int i = 0; i < 11; i++) axil_write(12'h080 + 12'(4 * i), 32'(taps[i]));
        axil_write(12'h014, 32'd11);
        for (int i = 0; i < 11; i++) rd_check($sformatf("tap%0d", i), 12'h080 + 12'(4 * i),
                                              32'(taps[i]));
        rd_check("tap_num", 12'h014, 32'd11);

        // Eleven-tap run over 1..8
        axil_write(12'h010, 32'd8);
        rd_check("data_length", 12'h010, 32'd8);
        axil_write(12'h000, 32'd1);
        for (int i = 0; i < 8; i++) begin
            send_sample(32'(i + 1));
            recv_out($sformatf("y%0d", i), 32'(exp_y[i]), i == 7);
        end
        repeat (2) @(negedge axis_clk);
        rd_check("ctrl_done", 12'h000, 32'h6);
        rd_check("ctrl_done_cleared", 12'h000, 32'h4);

        // Latency, backpressure and busy-time register rules
        axil_write(12'h080, 32'd1);
        axil_write(12'h084, 32'd2);
        axil_write(12'h088, 32'd3);
        axil_write(12'h014, 32'd3);
        axil_write(12'h010, 32'd2);
        axil_write(12'h000, 32'd1);
        send_sample(32'd5);
        begin
            int n = 0;
            while (!sm_tvalid && n < 100) begin
                @(negedge axis_clk);
                n++;
            end
        end
        lat = ($time - 5 - hs_time) / 10;
        check("latency_tap3", 32'(lat), 32'd4);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold_data%0d", i), sm_tdata, 32'd5);
            check($sformatf("hold_ss_tready%0d", i), {31'b0, ss_tready}, 32'd0);
            @(negedge axis_clk);
        end
        axil_write(12'h080, 32'd99);
        rd_check("tap_read_busy", 12'h080, 32'hFFFF_FFFF);
        rd_check("ctrl_busy", 12'h000, 32'h0);
        axil_write(12'h000, 32'd1);
        rd_check("ctrl_start_ignored", 12'h000, 32'h0);
        check("hold_data_after_axil", sm_tdata, 32'd5);
        recv_out("t3_y0", 32'd5, 1'b0);
        send_sample(32'd7);
        recv_out("t3_y1", 32'd17, 1'b1);
        repeat (2) @(negedge axis_clk);
        rd_check("tap0_kept", 12'h080, 32'd1);
        rd_check("ctrl_done_t3", 12'h000, 32'h6);
        rd_check("ctrl_clr_t3", 12'h000, 32'h4);

        // Zero-length run completes without stream traffic
        axil_write(12'h010, 32'd0);
        axil_write(12'h000, 32'd1);
        check("len0_stream_a", {30'b0, ss_tready, sm_tvalid}, 32'd0);
        @(negedge axis_clk);
        check("len0_stream_b", {30'b0, ss_tready, sm_tvalid}, 32'd0);
        rd_check("len0_done", 12'h000, 32'h6);
        rd_check("len0_clr", 12'h000, 32'h4);

        // Reset during MAC aborts the run
        axil_write(12'h010, 32'd1);
        axil_write(12'h000, 32'd1);
        send_sample(32'd4);
        axis_rst_n = 1'b0;
        #1;
        check("abort_ctl_outs", {25'b0, awready, wready, arready, rvalid, ss_tready, sm_tvalid,
                                 sm_tlast}, 32'd0);
        check("abort_sm_tdata", sm_tdata, 32'd0);
        check("abort_rdata", rdata, 32'd0);
        @(negedge axis_clk);
        axis_rst_n = 1'b1;
        @(negedge axis_clk);
        rd_check("abort_ctrl", 12'h000, 32'h4);
        rd_check("abort_tap_cleared", 12'h084, 32'd0);
        rd_check("abort_tap_num", 12'h014, 32'd0);
        axil_write(12'h080, 32'd1);
        axil_write(12'h084, 32'd2);
        axil_write(12'h088, 32'd3);
        axil_write(12'h014, 32'd3);
        axil_write(12'h010, 32'd1);
        axil_write(12'h000, 32'd1);
        send_sample(32'd4);
        recv_out("rerun_y0", 32'd4, 1'b1);

        // Saturation and unmapped address
        repeat (2) @(negedge axis_clk);
        axil_write(12'h014, 32'd40);
        rd_check("tap_num_sat", 12'h014, 32'd32);
        axil_write(12'h040, 32'd7);
        rd_check("unmapped", 12'h040, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

endmodule
